// File: rtl/regfile_resp_pkg.sv
// Shared constants for the traffic-light wait-time register file.
// Holds address map, data width, reset defaults and the reader FSM encoding.
package regfile_resp_pkg;

    localparam int AW   = 2;
    localparam int DW   = 3;
    localparam int NENT = 3;

    localparam logic [AW-1:0] ADDR_RED = 2'd0;
    localparam logic [AW-1:0] ADDR_GRN = 2'd1;
    localparam logic [AW-1:0] ADDR_YEL = 2'd2;
    localparam logic [AW-1:0] ADDR_RSV = 2'd3;

    localparam logic [DW-1:0] RED_DEF = 3'd5;
    localparam logic [DW-1:0] GRN_DEF = 3'd4;
    localparam logic [DW-1:0] YEL_DEF = 3'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    function automatic logic [DW-1:0] def_val(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = '0;
        unique case (a)
            ADDR_RED: v = RED_DEF;
            ADDR_GRN: v = GRN_DEF;
            ADDR_YEL: v = YEL_DEF;
            default:  v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/regfile_resp_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst (async high), d_i (async in), q_o (synchronized out).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/regfile_resp.sv
// regfile_resp: 3-entry wait-time config file with a 4-phase async read port.
// Ports: clk, rst (async high); wr_en/wr_addr/wr_data/cfg_commit config side,
// done level; r_en/r_addr request, r_data/ren_ack response.
// Macro REGFILE_SHADOW_EN: writes go to a shadow bank copied on cfg_commit.
module regfile_resp
    import regfile_resp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          cfg_commit,
    output logic          done,
    input  logic          r_en,
    input  logic [AW-1:0] r_addr,
    output logic [DW-1:0] r_data,
    output logic          ren_ack
);

    logic          ren_s2;
    state_e        state_q, state_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          done_q, done_d;
    logic [DW-1:0] act_q [NENT];
    logic [DW-1:0] act_d [NENT];
    logic [DW-1:0] rd_val;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (r_en),
        .q_o (ren_s2)
    );

`ifdef REGFILE_SHADOW_EN
    logic [DW-1:0] shd_q [NENT];
    logic [DW-1:0] shd_d [NENT];

    // Write lands in the shadow first so a same-cycle commit publishes it.
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            shd_d[i] = shd_q[i];
            act_d[i] = act_q[i];
        end
        for (int i = 0; i < NENT; i++) begin
            if (wr_en && wr_addr == AW'(i)) shd_d[i] = wr_data;
        end
        if (cfg_commit) begin
            for (int i = 0; i < NENT; i++) act_d[i] = shd_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) shd_q[i] <= def_val(AW'(i));
        end else begin
            for (int i = 0; i < NENT; i++) shd_q[i] <= shd_d[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            act_d[i] = act_q[i];
            if (wr_en && wr_addr == AW'(i)) act_d[i] = wr_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) act_q[i] <= def_val(AW'(i));
        end else begin
            for (int i = 0; i < NENT; i++) act_q[i] <= act_d[i];
        end
    end

    // Reserved address has no storage and reads as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NENT; i++) begin
            if (r_addr == AW'(i)) rd_val = act_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        rdata_d = rdata_q;
        done_d  = done_q | cfg_commit;
        unique case (state_q)
            ST_IDLE: begin
                if (ren_s2) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    rdata_d = rd_val;
                end
            end
            ST_ACK: begin
                if (!ren_s2) begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign ren_ack = ack_q;
    assign r_data  = rdata_q;
    assign done    = done_q;

endmodule

// File: tb/tb_regfile_resp.sv
// Bench for regfile_resp: directed table, corner sequences, random vs model.
// Reference model keeps the entries as plain arrays updated per operation.
module tb_regfile_resp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [2:0] wr_data = '0;
    logic       cfg_commit = 1'b0;
    logic       done;
    logic       r_en = 1'b0;
    logic [1:0] r_addr = '0;
    logic [2:0] r_data;
    logic       ren_ack;

    int total = 0;
    int bad = 0;

    logic [2:0] m_act [4];
    logic [2:0] m_sh [4];
    bit shadow_build;

    typedef enum int {OP_WR, OP_CM, OP_RD} op_e;
    typedef struct {
        op_e        op;
        logic [1:0] addr;
        logic [2:0] data;
        logic [2:0] exp;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    regfile_resp dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cfg_commit (cfg_commit),
        .done       (done),
        .r_en       (r_en),
        .r_addr     (r_addr),
        .r_data     (r_data),
        .ren_ack    (ren_ack)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_act[0] = 3'd5; m_act[1] = 3'd4; m_act[2] = 3'd1; m_act[3] = 3'd0;
        m_sh = m_act;
    endtask

    function automatic logic [2:0] model_rd(input logic [1:0] a);
        return (a == 2'd3) ? 3'd0 : m_act[a];
    endfunction

    // One cycle of config traffic; write (if any) applies before commit.
    task automatic cfg_op(input bit we, input logic [1:0] a,
                          input logic [2:0] d, input bit cm);
        @(negedge clk);
        wr_en = we; wr_addr = a; wr_data = d; cfg_commit = cm;
        @(negedge clk);
        wr_en = 1'b0; cfg_commit = 1'b0;
        if (we && a != 2'd3) begin
            if (shadow_build) m_sh[a] = d;
            else m_act[a] = d;
        end
        if (cm && shadow_build) m_act = m_sh;
    endtask

    task automatic wait_ack(input bit lvl, output int n);
        n = 0;
        while (n < 10) begin
            @(posedge clk); #1;
            n++;
            if (ren_ack == lvl) break;
        end
    endtask

    task automatic rd_start(input logic [1:0] a, input logic [2:0] exp,
                            input string nm);
        int n;
        @(negedge clk);
        r_addr = a; r_en = 1'b1;
        wait_ack(1'b1, n);
        chk({nm, "_lat"}, n, 3);
        chk({nm, "_data"}, r_data, exp);
    endtask

    task automatic rd_end(input string nm);
        int n;
        @(negedge clk);
        r_en = 1'b0;
        wait_ack(1'b0, n);
        chk({nm, "_droplat"}, n, 3);
    endtask

    task automatic rd(input logic [1:0] a, input logic [2:0] exp,
                      input string nm);
        rd_start(a, exp, nm);
        rd_end(nm);
    endtask

    initial begin
`ifdef REGFILE_SHADOW_EN
        shadow_build = 1'b1;
`else
        shadow_build = 1'b0;
`endif
        model_reset();

        tbl[0]  = '{OP_WR, 2'd2, 3'd3, 3'd0};
        tbl[1]  = '{OP_CM, 2'd0, 3'd0, 3'd0};
        tbl[2]  = '{OP_RD, 2'd2, 3'd0, 3'd3};
        tbl[3]  = '{OP_WR, 2'd3, 3'd7, 3'd0};
        tbl[4]  = '{OP_CM, 2'd0, 3'd0, 3'd0};
        tbl[5]  = '{OP_RD, 2'd3, 3'd0, 3'd0};
        tbl[6]  = '{OP_RD, 2'd0, 3'd0, 3'd2};
        tbl[7]  = '{OP_WR, 2'd0, 3'd0, 3'd0};
        tbl[8]  = '{OP_CM, 2'd0, 3'd0, 3'd0};
        tbl[9]  = '{OP_RD, 2'd0, 3'd0, 3'd0};
        tbl[10] = '{OP_WR, 2'd1, 3'd7, 3'd0};
        tbl[11] = '{OP_CM, 2'd0, 3'd0, 3'd0};
        tbl[12] = '{OP_RD, 2'd1, 3'd0, 3'd7};

        repeat (3) @(negedge clk);
        chk("rst_ack", ren_ack, 0);
        chk("rst_data", r_data, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        rd(2'd0, 3'd5, "rd_red_def");
        chk("done_pre", done, 0);

        cfg_op(1'b1, 2'd1, 3'd6, 1'b0);
        @(negedge clk);
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        chk("done_post", done, 1);
        @(negedge clk);
        cfg_commit = 1'b0;
        if (shadow_build) m_act = m_sh;
        rd(2'd1, 3'd6, "rd_grn6");

        cfg_op(1'b1, 2'd0, 3'd2, 1'b0);
        rd(2'd0, shadow_build ? 3'd5 : 3'd2, "rd_precommit");
        cfg_op(1'b0, 2'd0, 3'd0, 1'b1);
        rd(2'd0, 3'd2, "rd_postcommit");

        for (int i = 0; i < 13; i++) begin
            unique case (tbl[i].op)
                OP_WR: cfg_op(1'b1, tbl[i].addr, tbl[i].data, 1'b0);
                OP_CM: cfg_op(1'b0, 2'd0, 3'd0, 1'b1);
                default: rd(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
            endcase
        end

        cfg_op(1'b1, 2'd2, 3'd5, 1'b1);
        rd(2'd2, 3'd5, "wr_commit_same");

        cfg_op(1'b1, 2'd1, 3'd2, 1'b1);
        rd_start(2'd1, 3'd2, "hold");
        cfg_op(1'b1, 2'd1, 3'd7, 1'b0);
        cfg_op(1'b0, 2'd0, 3'd0, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_ack", ren_ack, 1);
        chk("hold_data", r_data, 2);
        rd_end("hold");
        rd(2'd1, 3'd7, "hold_next");

        rd_start(2'd0, model_rd(2'd0), "rstmid");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_ack", ren_ack, 0);
        chk("rstmid_data", r_data, 0);
        chk("rstmid_done", done, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        begin
            int n;
            wait_ack(1'b1, n);
            chk("rstmid_relat", n, 3);
            chk("rstmid_redata", r_data, 5);
        end
        rd_end("rstmid");

        for (int i = 0; i < 60; i++) begin
            int k;
            logic [1:0] a;
            logic [2:0] d;
            k = int'($urandom_range(0, 3));
            a = 2'($urandom_range(0, 3));
            d = 3'($urandom_range(0, 7));
            unique case (k)
                0: cfg_op(1'b1, a, d, 1'b0);
                1: cfg_op(1'b0, a, d, 1'b1);
                2: cfg_op(1'b1, a, d, 1'b1);
                default: rd(a, model_rd(a), $sformatf("rnd%0d", i));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
